// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM states and default constants for the program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEF_INCR         = 4;
    localparam int          DEF_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC priority mux (trap > redirect > advance > hold) with target alignment handling.
// PC_MISALIGN_CHECK_EN: misaligned targets are rejected and flagged; otherwise their low bits are cleared.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic            i_en,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus,
    input  logic            i_advance,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_vector,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    output logic [XLEN-1:0] o_pc_next,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_misalign_addr
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

    logic w_trap;
    logic w_redir;

    assign w_trap  = i_en & i_trap_valid;
    assign w_redir = i_en & i_redirect_valid;

`ifdef PC_MISALIGN_CHECK_EN
    logic w_trap_bad;
    logic w_take_trap;
    logic w_redir_bad;
    logic w_take_redir;

    // A rejected trap falls through to the redirect, which may itself be rejected.
    assign w_trap_bad   = w_trap && |(i_trap_vector & ~ALIGN_MASK);
    assign w_take_trap  = w_trap && !w_trap_bad;
    assign w_redir_bad  = w_redir && !w_take_trap && |(i_redirect_target & ~ALIGN_MASK);
    assign w_take_redir = w_redir && !w_take_trap && !w_redir_bad;

    assign o_pc_next = w_take_trap  ? i_trap_vector :
                       w_take_redir ? i_redirect_target :
                       i_advance    ? i_pc_plus : i_pc;
    assign o_misalign      = w_trap_bad | w_redir_bad;
    assign o_misalign_addr = w_trap_bad  ? i_trap_vector :
                             w_redir_bad ? i_redirect_target : '0;
`else
    assign o_pc_next = w_trap    ? i_trap_vector & ALIGN_MASK :
                       w_redir   ? i_redirect_target & ALIGN_MASK :
                       i_advance ? i_pc_plus : i_pc;
    assign o_misalign      = 1'b0;
    assign o_misalign_addr = '0;
`endif

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with trap/branch redirects, valid/ready offer and BOOT/RUN/HALTED control.
// Optional PC_MISALIGN_CHECK_EN rejects misaligned redirect targets and reports them on misalign/misalign_addr.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter int              INCR         = DEF_INCR,
    parameter int              ALIGN_BITS   = DEF_ALIGN_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            halted,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    pc_state_e       r_state;
    pc_state_e       w_state_nx;
    logic [XLEN-1:0] r_pc;
    logic            r_fetch_valid;
    logic            r_halted;
    logic            r_misalign;
    logic [XLEN-1:0] r_misalign_addr;
    logic [XLEN-1:0] w_pc_plus;
    logic [XLEN-1:0] w_pc_nx;
    logic            w_misalign;
    logic [XLEN-1:0] w_misalign_addr;

    assign w_pc_plus = r_pc + XLEN'(INCR);

    // Redirects are honoured in RUN and HALTED (debugger-set PC), never in BOOT.
    pc_next_sel #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_sel (
        .i_en              (r_state != BOOT),
        .i_pc              (r_pc),
        .i_pc_plus         (w_pc_plus),
        .i_advance         (r_fetch_valid & fetch_ready),
        .i_trap_valid      (trap_valid),
        .i_trap_vector     (trap_vector),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_pc_next         (w_pc_nx),
        .o_misalign        (w_misalign),
        .o_misalign_addr   (w_misalign_addr)
    );

    always_comb begin
        w_state_nx = (r_state == BOOT) ? RUN :
                     (r_state == RUN)  ? (halt_req ? HALTED : RUN) :
                     (resume_req && !halt_req) ? RUN : HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= BOOT;
            r_pc            <= RESET_VECTOR;
            r_fetch_valid   <= 1'b0;
            r_halted        <= 1'b0;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_state         <= w_state_nx;
            r_pc            <= w_pc_nx;
            r_fetch_valid   <= (w_state_nx == RUN);
            r_halted        <= (w_state_nx == HALTED);
            r_misalign      <= w_misalign;
            r_misalign_addr <= w_misalign_addr;
        end
    end

    assign fetch_valid   = r_fetch_valid;
    assign pc            = r_pc;
    assign pc_plus       = w_pc_plus;
    assign halted        = r_halted;
    assign misalign      = r_misalign;
    assign misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test-plan sequence plus randomized traffic checked against a behavioural PC model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        halt_req;
    logic        resume_req;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        halted;
    logic        misalign;
    logic [31:0] misalign_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Model: boot/halt flags, PC and last-cycle misalign report.
    bit          m_boot;
    bit          m_halt;
    logic [31:0] m_pc;
    bit          m_mis;
    logic [31:0] m_mis_addr;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .halt_req        (halt_req),
        .resume_req      (resume_req),
        .fetch_valid     (fetch_valid),
        .pc              (pc),
        .pc_plus         (pc_plus),
        .halted          (halted),
        .misalign        (misalign),
        .misalign_addr   (misalign_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [31:0] nx;
        bit          took;
        bit          running;
        running    = !m_boot && !m_halt;
        nx         = m_pc;
        took       = 0;
        m_mis      = 0;
        m_mis_addr = 32'h0;
        if (rst) begin
            m_boot = 1;
            m_halt = 0;
            m_pc   = 32'h0;
            return;
        end
        if (!m_boot) begin
`ifdef PC_MISALIGN_CHECK_EN
            if (trap_valid) begin
                if (trap_vector[1:0] == 2'b00) begin
                    nx = trap_vector;
                    took = 1;
                end else begin
                    m_mis = 1;
                    m_mis_addr = trap_vector;
                end
            end
            if (!took && redirect_valid) begin
                if (redirect_target[1:0] == 2'b00) begin
                    nx = redirect_target;
                    took = 1;
                end else if (!m_mis) begin
                    m_mis = 1;
                    m_mis_addr = redirect_target;
                end
            end
`else
            if (trap_valid) begin
                nx = {trap_vector[31:2], 2'b00};
                took = 1;
            end else if (redirect_valid) begin
                nx = {redirect_target[31:2], 2'b00};
                took = 1;
            end
`endif
            if (!took && running && fetch_ready) nx = m_pc + 32'd4;
        end
        m_pc = nx;
        if (m_boot) m_boot = 0;
        else if (running) m_halt = halt_req;
        else if (resume_req && !halt_req) m_halt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("pc", pc, m_pc);
        check("pc_plus", pc_plus, m_pc + 32'd4);
        check("fetch_valid", 32'(fetch_valid), 32'(!m_boot && !m_halt));
        check("halted", 32'(halted), 32'(m_halt));
        check("misalign", 32'(misalign), 32'(m_mis));
        check("misalign_addr", misalign_addr, m_mis_addr);
    endtask

    task automatic drive(input bit r, input bit rdy, input bit rv, input logic [31:0] rt,
                         input bit tv, input logic [31:0] tt, input bit hr, input bit rr);
        rst = r;
        fetch_ready = rdy;
        redirect_valid = rv;
        redirect_target = rt;
        trap_valid = tv;
        trap_vector = tt;
        halt_req = hr;
        resume_req = rr;
        step();
    endtask

    initial begin
        m_boot = 1;
        m_halt = 0;
        m_pc = 32'h0;
        m_mis = 0;
        m_mis_addr = 32'h0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_pc", pc, 32'h0);
        check("reset_pc_plus", pc_plus, 32'h4);
        check("reset_valid", 32'(fetch_valid), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        check("boot_exit_pc", pc, 32'h0);
        check("run_valid", 32'(fetch_valid), 32'd1);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        check("adv_4", pc, 32'h4);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        check("adv_8", pc, 32'h8);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            check("stall_hold", pc, 32'h8);
            check("stall_valid", 32'(fetch_valid), 32'd1);
        end
        drive(0, 0, 1, 32'h100, 1, 32'h200, 0, 0);
        check("trap_over_redirect", pc, 32'h200);
        drive(0, 0, 1, 32'h10, 0, 0, 0, 0);
        check("redirect_no_ready", pc, 32'h10);
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        check("halt_pc", pc, 32'h14);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_valid", 32'(fetch_valid), 32'd0);
        drive(0, 1, 0, 0, 0, 0, 1, 1);
        check("halt_and_resume_stays", 32'(halted), 32'd1);
        drive(0, 1, 1, 32'h40, 0, 0, 0, 0);
        check("halted_redirect", pc, 32'h40);
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        check("resume_pc", pc, 32'h40);
        check("resume_valid", 32'(fetch_valid), 32'd1);
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        check("top_pc_plus", pc_plus, 32'h0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        check("wrap", pc, 32'h0);
        drive(1, 1, 1, 32'h300, 1, 32'h400, 0, 0);
        check("rst_over_redirect", pc, 32'h0);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 32'h102, 0, 0, 0, 0);
`ifdef PC_MISALIGN_CHECK_EN
        check("misalign_pc", pc, 32'h4);
        check("misalign_flag", 32'(misalign), 32'd1);
        check("misalign_addr", misalign_addr, 32'h102);
`else
        check("force_align", pc, 32'h100);
        check("misalign_tied", 32'(misalign), 32'd0);
`endif
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rt;
            logic [31:0] tt;
            rt = $urandom;
            tt = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) tt[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rt = 32'hFFFF_FFFC;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, rt, $urandom_range(0, 15) == 0, tt,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
